// File: rtl/debug_cmd_loader_pkg.sv
// Shared constants for the UART debug command loader: host command codes,
// reply bytes and the state encoding whose value doubles as the o_state bit index.
package debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_DUMP = 8'h04;
    localparam logic [7:0] ACK_BASE = 8'h80;
    localparam logic [7:0] NAK_BYTE = 8'hFF;

    localparam int ST_IDLE      = 0;
    localparam int ST_LOAD_LEN  = 1;
    localparam int ST_LOAD_BYTE = 2;
    localparam int ST_LOAD_WR   = 3;
    localparam int ST_RUN       = 4;
    localparam int ST_STEP      = 5;
    localparam int ST_DUMP_RD   = 6;
    localparam int ST_DUMP_TX   = 7;
    localparam int ST_DUMP_WAIT = 8;
    localparam int ST_ACK       = 9;

    // Enum values equal the one-hot bit indices above.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_LEN  = 4'd1,
        S_LOAD_BYTE = 4'd2,
        S_LOAD_WR   = 4'd3,
        S_RUN       = 4'd4,
        S_STEP      = 4'd5,
        S_DUMP_RD   = 4'd6,
        S_DUMP_TX   = 4'd7,
        S_DUMP_WAIT = 4'd8,
        S_ACK       = 4'd9
    } state_e;

endpackage

// File: rtl/debug_cmd_loader_if.sv
// Bundle of UART byte handshake, instruction-memory write, core control and
// readback signals between the debug loader (master) and its surroundings (slave).
interface debug_cmd_loader_if #(
    parameter int BYTE         = 8,
    parameter int NB_INST      = 32,
    parameter int NB_IM_ADDR   = 6,
    parameter int NB_DUMP_ADDR = 5,
    parameter int NB_ST        = 10
);
    logic                    i_rx_done;
    logic [BYTE-1:0]         i_rx_data;
    logic                    i_tx_done;
    logic                    o_tx_start;
    logic [BYTE-1:0]         o_tx_data;
    logic                    o_im_we;
    logic [NB_IM_ADDR-1:0]   o_im_addr;
    logic [NB_INST-1:0]      o_im_data;
    logic                    o_cpu_en;
    logic                    i_halt;
    logic [NB_DUMP_ADDR-1:0] o_dump_addr;
    logic [NB_INST-1:0]      i_dump_data;
    logic [NB_ST-1:0]        o_state;

    modport master (
        input  i_rx_done, i_rx_data, i_tx_done, i_halt, i_dump_data,
        output o_tx_start, o_tx_data, o_im_we, o_im_addr, o_im_data,
               o_cpu_en, o_dump_addr, o_state
    );

    modport slave (
        output i_rx_done, i_rx_data, i_tx_done, i_halt, i_dump_data,
        input  o_tx_start, o_tx_data, o_im_we, o_im_addr, o_im_data,
               o_cpu_en, o_dump_addr, o_state
    );
endinterface

// File: rtl/debug_cmd_loader_edge_pulse.sv
// Rising-edge detector for a level that may stay high several cycles:
// one sampling stage, one history stage, pulse lasts one cycle.
module edge_pulse (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_level,
    output logic o_pulse
);
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        sync_d = i_level;
        prev_d = sync_q;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_pulse = sync_q & ~prev_q;
endmodule

// File: rtl/debug_cmd_loader.sv
// UART-side debug controller: decodes one-byte host commands to load
// instruction memory, run/step the core, or dump readback words, then acks.
module debug_cmd_loader
    import debug_pkg::*;
#(
    parameter int BYTE       = 8,
    parameter int NB_INST    = 32,
    parameter int IM_WORDS   = 64,
    parameter int DUMP_WORDS = 32,
    parameter int NB_ST      = 10
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    debug_cmd_loader_if.master bus
);
    localparam int BPW          = NB_INST / BYTE;
    localparam int NB_IM_ADDR   = $clog2(IM_WORDS);
    localparam int NB_DUMP_ADDR = $clog2(DUMP_WORDS);
    localparam int NB_BCNT      = $clog2(BPW + 1);

    logic [1:0] done_lvl, done_pulse;
    logic       rx_pulse, tx_pulse;

    state_e                  state_q,     state_d;
    logic [BYTE-1:0]         rx_byte_q,   rx_byte_d;
    logic [BYTE-1:0]         cmd_q,       cmd_d;
    logic                    nak_q,       nak_d;
    logic [NB_IM_ADDR:0]     n_words_q,   n_words_d;
    logic [NB_IM_ADDR:0]     im_addr_q,   im_addr_d;
    logic [NB_BCNT-1:0]      byte_cnt_q,  byte_cnt_d;
    logic [NB_INST-1:0]      word_q,      word_d;
    logic [NB_DUMP_ADDR:0]   dump_addr_q, dump_addr_d;
    logic [NB_INST-1:0]      shift_q,     shift_d;
    logic                    tx_start_q,  tx_start_d;
    logic [BYTE-1:0]         tx_data_q,   tx_data_d;
    logic                    ack_sent_q,  ack_sent_d;

    assign done_lvl = {bus.i_tx_done, bus.i_rx_done};

    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
        edge_pulse u_edge (
            .i_clock   (i_clock),
            .i_reset_n (i_reset_n),
            .i_level   (done_lvl[gi]),
            .o_pulse   (done_pulse[gi])
        );
    end

    assign rx_pulse = done_pulse[0];
    assign tx_pulse = done_pulse[1];

    always_comb begin
        state_d     = state_q;
        rx_byte_d   = bus.i_rx_data;   // same delay as the edge sampler, so data lines up with rx_pulse
        cmd_d       = cmd_q;
        nak_d       = nak_q;
        n_words_d   = n_words_q;
        im_addr_d   = im_addr_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        dump_addr_d = dump_addr_q;
        shift_d     = shift_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        ack_sent_d  = ack_sent_q;

        unique case (state_q)
            S_IDLE: if (rx_pulse) begin
                cmd_d = rx_byte_q;
                nak_d = 1'b0;
                if (rx_byte_q == BYTE'(CMD_LOAD))      state_d = S_LOAD_LEN;
                else if (rx_byte_q == BYTE'(CMD_RUN))  state_d = S_RUN;
                else if (rx_byte_q == BYTE'(CMD_STEP)) state_d = S_STEP;
                else if (rx_byte_q == BYTE'(CMD_DUMP)) begin
                    dump_addr_d = '0;
                    state_d     = S_DUMP_RD;
                end else begin
                    nak_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_LOAD_LEN: if (rx_pulse) begin
                if (int'(rx_byte_q) > IM_WORDS) begin
                    nak_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    // A zero count is the "whole memory" shorthand.
                    n_words_d  = (rx_byte_q == '0) ? (NB_IM_ADDR+1)'(IM_WORDS)
                                                   : (NB_IM_ADDR+1)'(rx_byte_q);
                    im_addr_d  = '0;
                    byte_cnt_d = '0;
                    state_d    = S_LOAD_BYTE;
                end
            end
            S_LOAD_BYTE: if (rx_pulse) begin
                word_d = (word_q << BYTE) | NB_INST'(rx_byte_q);
                if (byte_cnt_q == NB_BCNT'(BPW - 1)) begin
                    byte_cnt_d = '0;
                    state_d    = S_LOAD_WR;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            S_LOAD_WR: begin
                im_addr_d = im_addr_q + 1'b1;
                state_d   = (im_addr_q + 1'b1 == n_words_q) ? S_ACK : S_LOAD_BYTE;
            end
            S_RUN:  if (bus.i_halt) state_d = S_ACK;
            S_STEP: state_d = S_ACK;
            S_DUMP_RD: state_d = S_DUMP_TX;
            S_DUMP_TX: begin
                shift_d    = bus.i_dump_data;
                tx_start_d = 1'b1;
                tx_data_d  = bus.i_dump_data[NB_INST-1 -: BYTE];
                byte_cnt_d = NB_BCNT'(1);
                state_d    = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: if (tx_pulse) begin
                if (byte_cnt_q == NB_BCNT'(BPW)) begin
                    byte_cnt_d = '0;
                    if (dump_addr_q == (NB_DUMP_ADDR+1)'(DUMP_WORDS - 1)) begin
                        dump_addr_d = '0;
                        state_d     = S_ACK;
                    end else begin
                        dump_addr_d = dump_addr_q + 1'b1;
                        state_d     = S_DUMP_RD;
                    end
                end else begin
                    shift_d    = shift_q << BYTE;
                    tx_data_d  = shift_d[NB_INST-1 -: BYTE];
                    tx_start_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                // First cycle launches the reply; afterwards wait for it to leave.
                if (!ack_sent_q) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = nak_q ? BYTE'(NAK_BYTE) : (BYTE'(ACK_BASE) | cmd_q);
                    ack_sent_d = 1'b1;
                end else if (tx_pulse) begin
                    ack_sent_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            rx_byte_q   <= '0;
            cmd_q       <= '0;
            nak_q       <= 1'b0;
            n_words_q   <= '0;
            im_addr_q   <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            dump_addr_q <= '0;
            shift_q     <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            ack_sent_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_byte_q   <= rx_byte_d;
            cmd_q       <= cmd_d;
            nak_q       <= nak_d;
            n_words_q   <= n_words_d;
            im_addr_q   <= im_addr_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            dump_addr_q <= dump_addr_d;
            shift_q     <= shift_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            ack_sent_q  <= ack_sent_d;
        end
    end

    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_im_we     = (state_q == S_LOAD_WR);
    assign bus.o_im_addr   = im_addr_q[NB_IM_ADDR-1:0];
    assign bus.o_im_data   = word_q;
    assign bus.o_cpu_en    = (state_q == S_RUN) || (state_q == S_STEP);
    assign bus.o_dump_addr = dump_addr_q[NB_DUMP_ADDR-1:0];
    assign bus.o_state     = NB_ST'(1) << state_q;
endmodule

// File: tb/tb_debug_cmd_loader.sv
// Randomized bench for debug_cmd_loader: host byte driver, tx/readback/core models
// and a command-level reference model of writes, replies and enable cycles.
module tb_debug_cmd_loader;
    localparam int BYTE = 8, NB_INST = 32, IM_WORDS = 64, DUMP_WORDS = 32, NB_ST = 10;
    localparam int BPW = NB_INST / BYTE;
    localparam int NB_IM_ADDR = 6, NB_DUMP_ADDR = 5;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_cmd_loader_if #(.BYTE(BYTE), .NB_INST(NB_INST), .NB_IM_ADDR(NB_IM_ADDR),
                          .NB_DUMP_ADDR(NB_DUMP_ADDR), .NB_ST(NB_ST)) bus ();

    debug_cmd_loader #(.BYTE(BYTE), .NB_INST(NB_INST), .IM_WORDS(IM_WORDS),
                       .DUMP_WORDS(DUMP_WORDS), .NB_ST(NB_ST)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] we_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  load_bytes[$];
    int cpu_total = 0;
    int tx_overlap = 0;
    int tx_unstable = 0;
    bit tx_busy = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tx_first();
        return (tx_q.size() > 0) ? {56'b0, tx_q[0]} : 64'h100;
    endfunction

    // Readback port: registered, answers one cycle after the address.
    always @(posedge clk) bus.i_dump_data <= {4{8'(bus.o_dump_addr)}};

    // Write strobe and core-enable monitors.
    always @(negedge clk) begin
        if (bus.o_im_we) we_q.push_back({26'b0, bus.o_im_addr, bus.o_im_data});
        if (bus.o_cpu_en) cpu_total <= cpu_total + 1;
    end

    // UART tx model: random byte time, done held 1-2 cycles.
    initial begin
        int cnt, done_cnt;
        logic [7:0] cur;
        bus.i_tx_done = 1'b0;
        cnt = 0; done_cnt = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) bus.i_tx_done = 1'b0;
            end
            if (bus.o_tx_start) begin
                if (tx_busy) tx_overlap++;
                cur = bus.o_tx_data;
                tx_q.push_back(cur);
                tx_busy = 1'b1;
                cnt = $urandom_range(3, 8);
            end else if (tx_busy) begin
                if (bus.o_tx_data !== cur) tx_unstable++;
                cnt--;
                if (cnt == 0) begin
                    tx_busy = 1'b0;
                    bus.i_tx_done = 1'b1;
                    done_cnt = $urandom_range(1, 2);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        repeat (2 + $urandom_range(0, 2)) @(posedge clk);
        #1;
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.i_rx_done = 1'b0;
    endtask

    task automatic wait_done(input int n_tx);
        int t = 0;
        while ((tx_q.size() < n_tx || bus.o_state != 10'd1 || tx_busy) && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) check("timeout", 64'(t), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] nbyte, input int hold);
        int nw;
        logic [31:0] w;
        we_q.delete(); tx_q.delete();
        nw = (nbyte == 0) ? IM_WORDS : int'(nbyte);
        send_byte(8'h01, hold);
        send_byte(nbyte, hold);
        if (nw > IM_WORDS) begin
            wait_done(1);
            check("nak_len_writes", 64'(we_q.size()), 0);
            check("nak_len_reply", tx_first(), 64'hFF);
            $display("load N=%0d -> nak, writes=%0d", nw, we_q.size());
        end else begin
            while (load_bytes.size() < nw * BPW) load_bytes.push_back(8'($urandom));
            for (int i = 0; i < nw * BPW; i++) send_byte(load_bytes[i], hold);
            wait_done(1);
            check("load_writes", 64'(we_q.size()), 64'(nw));
            for (int i = 0; i < nw && i < we_q.size(); i++) begin
                w = 0;
                for (int k = 0; k < BPW; k++) w = w * 256 + 32'(load_bytes[i * BPW + k]);
                check("load_addr", 64'(we_q[i][37:32]), 64'(i));
                check("load_data", 64'(we_q[i][31:0]), 64'(w));
            end
            check("load_reply", tx_first(), 64'h81);
            check("load_reply_count", 64'(tx_q.size()), 1);
            $display("load N=%0d hold=%0d -> writes=%0d reply=%0h", nw, hold, we_q.size(), tx_first());
        end
        load_bytes.delete();
    endtask

    task automatic do_run(input int k, input bit halt_on_entry);
        int cnt = 0, t = 0;
        tx_q.delete();
        bus.i_halt = halt_on_entry;
        cpu_total = 0;
        send_byte(8'h02, 1);
        if (!halt_on_entry) begin
            while (cnt < k && t < LIMIT) begin
                @(negedge clk);
                if (bus.o_cpu_en) cnt++;
                t++;
            end
            bus.i_halt = 1'b1;
        end
        wait_done(1);
        bus.i_halt = 1'b0;
        check("run_enable_cycles", 64'(cpu_total), halt_on_entry ? 64'd1 : 64'(k));
        check("run_reply", tx_first(), 64'h82);
        $display("run halt_after=%0d -> enabled=%0d reply=%0h", k, cpu_total, tx_first());
    endtask

    task automatic do_cmd_simple(input logic [7:0] cmd, input logic [7:0] exp_reply, input int exp_en);
        tx_q.delete();
        cpu_total = 0;
        send_byte(cmd, $urandom_range(1, 3));
        wait_done(1);
        check("cmd_reply", tx_first(), 64'(exp_reply));
        check("cmd_enable_cycles", 64'(cpu_total), 64'(exp_en));
        $display("cmd %02h -> reply=%0h enabled=%0d", cmd, tx_first(), cpu_total);
    endtask

    initial begin
        bus.i_rx_done = 1'b0; bus.i_rx_data = '0; bus.i_halt = 1'b0;

        // Reset held with rx traffic present.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            bus.i_rx_done = $urandom_range(0, 1);
            bus.i_rx_data = 8'($urandom_range(1, 4));
        end
        bus.i_rx_done = 1'b0;
        @(negedge clk);
        check("rst_state", 64'(bus.o_state), 64'h001);
        check("rst_writes", 64'(we_q.size()), 0);
        check("rst_tx", 64'(tx_q.size()), 0);
        check("rst_outputs", {bus.o_cpu_en, bus.o_im_we, bus.o_tx_start, bus.o_tx_data,
                              bus.o_im_addr, bus.o_dump_addr}, 0);
        check("rst_im_data", 64'(bus.o_im_data), 0);
        $display("reset held -> state=%0h", bus.o_state);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed two-word load from the test plan.
        load_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        do_load(8'h02, 2);

        // Random loads, including the full-memory N=0 case.
        for (int r = 0; r < 3; r++) do_load(8'($urandom_range(1, 8)), $urandom_range(1, 3));
        do_load(8'h00, 1);

        // Oversized lengths and unknown commands are refused.
        do_load(8'(IM_WORDS + 1), 1);
        do_load(8'($urandom_range(IM_WORDS + 2, 255)), 2);
        do_cmd_simple(8'h07, 8'hFF, 0);
        do_cmd_simple(8'h00, 8'hFF, 0);
        do_cmd_simple(8'($urandom_range(5, 254)), 8'hFF, 0);

        // Run / step.
        do_run(50, 1'b0);
        do_run($urandom_range(2, 40), 1'b0);
        do_run(1, 1'b1);
        do_cmd_simple(8'h03, 8'h83, 1);

        // Dump: each address byte four times, then the ack.
        tx_q.delete();
        send_byte(8'h04, 1);
        wait_done(BPW * DUMP_WORDS + 1);
        check("dump_count", 64'(tx_q.size()), 64'(BPW * DUMP_WORDS + 1));
        for (int i = 0; i < BPW * DUMP_WORDS && i < tx_q.size(); i++)
            check("dump_byte", 64'(tx_q[i]), 64'(i / BPW));
        if (tx_q.size() > BPW * DUMP_WORDS) check("dump_reply", 64'(tx_q[BPW * DUMP_WORDS]), 64'h84);
        check("tx_overlap", 64'(tx_overlap), 0);
        check("tx_unstable", 64'(tx_unstable), 0);
        $display("dump -> bytes=%0d", tx_q.size());

        // Reset pulsed after the 5th data byte of a load.
        we_q.delete(); tx_q.delete();
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check("midload_rst_state", 64'(bus.o_state), 64'h001);
        check("midload_rst_we", 64'(bus.o_im_we), 0);
        we_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_writes", 64'(we_q.size()), 0);
        check("post_rst_state", 64'(bus.o_state), 64'h001);
        $display("reset mid-load -> state=%0h writes=%0d", bus.o_state, we_q.size());
        do_load(8'h01, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=expired expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/debug_cmd_loader.md
# debug_cmd_loader

UART-side debug controller between the byte-level UART (rx/tx) and the pipelined MIPS core. It decodes one-byte host commands and performs four jobs: length-prefixed instruction-memory load, continuous run until halt, single step, and a word dump of a readback port (register file/PC bank) back over tx. Every command ends with an ack or nak byte. It generalises the fixed 256-byte load of the current debug path: word width, memory depth and dump depth are parametric.

## Interface
- BYTE, 8: UART byte width.
- NB_INST, 32: instruction/dump word width; must be a multiple of BYTE. Derived BPW = NB_INST/BYTE.
- IM_WORDS, 64: instruction-memory depth in words. Derived NB_IM_ADDR = clog2(IM_WORDS).
- DUMP_WORDS, 32: words returned by the dump command. Derived NB_DUMP_ADDR = clog2(DUMP_WORDS).
- NB_ST, 10: one-hot state vector width.

Ports:
- i_clock  in  1  single clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rx_done  in  1  rx byte valid; may be held more than one cycle.
- i_rx_data  in  BYTE  received byte.
- i_tx_done  in  1  tx finished the current byte; may be held more than one cycle.
- o_tx_start  out  1  one-cycle pulse that starts a tx byte.
- o_tx_data  out  BYTE  byte to send; stable from the start pulse until tx_done.
- o_im_we  out  1  instruction-memory write strobe, one cycle.
- o_im_addr  out  NB_IM_ADDR  word address.
- o_im_data  out  NB_INST  assembled word.
- o_cpu_en  out  1  core clock-enable.
- i_halt  in  1  core executed HALT.
- o_dump_addr  out  NB_DUMP_ADDR  readback address.
- i_dump_data  in  NB_INST  readback data; registered, valid one cycle after the address.
- o_state  out  NB_ST  one-hot current state, for LEDs.

## Operation
- States (one-hot bit index): IDLE 0, LOAD_LEN 1, LOAD_BYTE 2, LOAD_WR 3, RUN 4, STEP 5, DUMP_RD 6, DUMP_TX 7, DUMP_WAIT 8, ACK 9.
- Accepted rx byte: a rising edge of i_rx_done. Accepted tx completion: a rising edge of i_tx_done. Both edge detectors have one register stage.
- IDLE, on an accepted byte, decodes the command:
  - 0x01 goes to LOAD_LEN.
  - 0x02 goes to RUN.
  - 0x03 goes to STEP.
  - 0x04 goes to DUMP_RD with o_dump_addr=0.
  - Any other value goes to ACK with nak.
- LOAD_LEN: the next byte is N, the word count.
  - N=0 means IM_WORDS.
  - N>IM_WORDS gives a nak; nothing is written.
  - Otherwise clear the address and the byte counter, then go to LOAD_BYTE.
- LOAD_BYTE: shift bytes in MSB first. After BPW bytes, go to LOAD_WR.
- LOAD_WR: pulse o_im_we for one cycle with the current address and word. Then increment the address. After N words, go to ACK (ack); otherwise return to LOAD_BYTE.
- RUN: o_cpu_en=1 until i_halt=1 is sampled, then go to ACK. Rx bytes are ignored.
- STEP: o_cpu_en=1 for exactly one cycle, then go to ACK.
- DUMP_RD: wait one cycle for the read, then go to DUMP_TX.
- DUMP_TX: latch i_dump_data; pulse o_tx_start with the MSB byte; go to DUMP_WAIT.
- DUMP_WAIT: on each tx completion, send the next byte.
  - After BPW bytes, increment o_dump_addr and return to DUMP_RD.
  - After DUMP_WORDS words, go to ACK.
- ACK: send 0x80|cmd for success or 0xFF for nak. Wait for tx completion, then go to IDLE.
- Rx bytes arriving in RUN, STEP, the dump states or ACK are dropped.

## Timing
- Reset (i_reset_n=0, asynchronous) puts the block in IDLE.
  - o_state=10'b1.
  - All other outputs and counters are 0.
  - Reset mid-load or mid-tx aborts immediately; no strobe follows reset release.
- Command latency: the state changes 2 cycles after the i_rx_done rising edge (sync plus edge).
- Write timing: o_im_we is asserted the cycle after the last byte of the word is accepted.
- o_cpu_en, STEP: high for exactly 1 cycle.
- o_cpu_en, RUN: rises 1 cycle after decode and drops in the cycle i_halt is sampled high.
  - i_halt already high on entry gives exactly one enabled cycle.
- o_tx_start never reasserts before the tx completion for the previous byte.
- Address wraps are impossible: N is bounded by IM_WORDS, and the counters are sized with one extra bit.

## Structure
- debug_pkg holds:
  - the command codes (0x01–0x04), the ack base 0x80 and the nak value 0xFF;
  - the one-hot state index localparams.
- One sub-module, edge_pulse: a rising-edge detector, instantiated for rx_done and tx_done.

## Test plan
- Reset held with rx traffic present -> o_state=0x001, no o_im_we, no o_tx_start.
- Load: 0x01, 0x02, then 0x12 0x34 0x56 0x78 0x9A 0xBC 0xDE 0xF0, with rx_done held 2 cycles each -> exactly two writes: addr0=0x12345678, addr1=0x9ABCDEF0; tx 0x81.
- Load with N=IM_WORDS+1 -> no o_im_we; tx 0xFF. Unknown cmd 0x07 -> tx 0xFF.
- Run: 0x02, with i_halt raised 50 cycles later -> o_cpu_en high for 50 cycles; tx 0x82. Step: 0x03 -> o_cpu_en high for 1 cycle; tx 0x83.
- Dump with i_dump_data = {addr, addr, addr, addr} bytes -> 4·DUMP_WORDS bytes 0x00…0x1F, each repeated 4 times, then 0x84.
- i_reset_n pulsed low after the 5th byte of a load -> IDLE; a following 0x01 load proceeds from addr 0.
